// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte sources. Each granted byte
//   is latched, handed to the transmitter with a one-cycle start pulse, and
//   the arbiter then follows the transmitter Busy line until the frame ends.
//   If Busy never rises within BUSY_TIMEOUT cycles, the byte is dropped and
//   Timeout_Err pulses.
//
// Ports
//   CLK            clock
//   RST            asynchronous reset, active-low
//   Req            per-requester request level, held until its Req_Ack
//   Req_Data       requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   Req_Ack        one-hot, one-cycle pulse: byte accepted
//   Tx_Busy        Busy from the UART TX controller
//   Tx_Data        byte to the transmitter, held until the next grant
//   Tx_Data_Valid  one-cycle start pulse to the transmitter
//   Grant_Id       index of the current/last granted requester
//   Arb_Busy       high in every state except IDLE
//   Timeout_Err    one-cycle pulse when Busy fails to rise in time
//
// Build option
//   UART_ARB_FIXED_PRIO_EN : when defined, the lowest-index request always
//   wins and the round-robin pointer is not built.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a request while the transmitter is idle
// ISSUE      | Req_Ack is visible; the start pulse is launched this cycle
// WAIT_BUSY  | start pulse visible / waiting for Tx_Busy to rise
// WAIT_DONE  | frame in flight, waiting for Tx_Busy to fall
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ID_WIDTH     = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ack,
  input  logic                          Tx_Busy,
  output logic [DATA_WIDTH-1:0]         Tx_Data,
  output logic                          Tx_Data_Valid,
  output logic [ID_WIDTH-1:0]           Grant_Id,
  output logic                          Arb_Busy,
  output logic                          Timeout_Err
);

  localparam int                CNT_W     = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [ID_WIDTH-1:0]     ptr;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    found;
  logic [ID_WIDTH-1:0]     offset;
  logic [ID_WIDTH:0]       win_sum;
  logic [ID_WIDTH-1:0]     winner;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0]      win_onehot;
  logic                    grant;

  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [NUM_REQ-1:0]      ack_nxt;
  logic                    valid_nxt;
  logic [ID_WIDTH-1:0]     gid_nxt;
  logic                    busy_nxt;
  logic                    err_nxt;

  // Rotate the request vector so the pointer position lands at bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign req_rot = NUM_REQ'({Req, Req} >> ptr);

  always_comb begin
    found  = |req_rot;
    offset = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) offset = ID_WIDTH'(j);
    end
    win_sum = {1'b0, ptr} + {1'b0, offset};
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    winner = win_sum[ID_WIDTH-1:0];
  end

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_WIDTH'(i)) begin
        win_data      = Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign grant = (state == S_IDLE) && found && !Tx_Busy;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Pointer pinned at 0: the rotation above degenerates to lowest-index wins.
  assign ptr = '0;
`else
  logic [ID_WIDTH:0] ptr_inc;

  always_comb begin
    ptr_inc = {1'b0, winner} + (ID_WIDTH + 1)'(1);
    if (ptr_inc == NUM_REQ_W) ptr_inc = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       ptr <= '0;
    else if (grant) ptr <= ptr_inc[ID_WIDTH-1:0];
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      Tx_Data       <= '0;
      Tx_Data_Valid <= 1'b0;
      Req_Ack       <= '0;
      Grant_Id      <= '0;
      Arb_Busy      <= 1'b0;
      Timeout_Err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      Tx_Data       <= data_nxt;
      Tx_Data_Valid <= valid_nxt;
      Req_Ack       <= ack_nxt;
      Grant_Id      <= gid_nxt;
      Arb_Busy      <= busy_nxt;
      Timeout_Err   <= err_nxt;
    end
  end

  // Outputs are registered, so each one is computed here from the state it
  // will describe in the next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = Tx_Data;
    gid_nxt   = Grant_Id;
    ack_nxt   = '0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = S_ISSUE;
          data_nxt  = win_data;
          gid_nxt   = winner;
          ack_nxt   = win_onehot;
        end
      end
      S_ISSUE: begin
        valid_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (Tx_Busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          // Byte is dropped; the pointer already moved past this requester.
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!Tx_Busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. A transaction-level model keeps
//   only the round-robin pointer and picks each winner from the request
//   pattern; the bench plays the UART TX controller (Busy two cycles after
//   the start pulse, or never, to force a timeout).
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int BT = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    Req = '0;
  logic [N*DW-1:0] Req_Data = '0;
  logic [N-1:0]    Req_Ack;
  logic            Tx_Busy = 1'b0;
  logic [DW-1:0]   Tx_Data;
  logic            Tx_Data_Valid;
  logic [IW-1:0]   Grant_Id;
  logic            Arb_Busy;
  logic            Timeout_Err;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BUSY_TIMEOUT(BT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Req(Req),
    .Req_Data(Req_Data),
    .Req_Ack(Req_Ack),
    .Tx_Busy(Tx_Busy),
    .Tx_Data(Tx_Data),
    .Tx_Data_Valid(Tx_Data_Valid),
    .Grant_Id(Grant_Id),
    .Arb_Busy(Arb_Busy),
    .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference winner: first set request at or above the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"},   32'(Req_Ack), 32'h0);
    check_eq({tag, "_data"},  32'(Tx_Data), 32'h0);
    check_eq({tag, "_valid"}, 32'(Tx_Data_Valid), 32'h0);
    check_eq({tag, "_gid"},   32'(Grant_Id), 32'h0);
    check_eq({tag, "_busy"},  32'(Arb_Busy), 32'h0);
    check_eq({tag, "_terr"},  32'(Timeout_Err), 32'h0);
  endtask

  // Called in a cycle where the arbiter is idle. busy_len = 0 means the
  // transmitter never answers. Returns in the arbiter's next idle cycle.
  task automatic do_frame(input logic [N-1:0] req, input logic [N*DW-1:0] data,
                          input int busy_len, input bit drop);
    int w;
    logic [DW-1:0] d;
    Req      = req;
    Req_Data = data;
    w        = model_pick(req);
    d        = data[w*DW +: DW];
    ptr_m    = (w + 1) % N;

    tick();
    check_eq("ack_onehot", 32'(Req_Ack), 32'(1 << w));
    check_eq("grant_id",   32'(Grant_Id), 32'(w));
    check_eq("tx_data",    32'(Tx_Data), 32'(d));
    check_eq("valid_vs_ack", 32'(Tx_Data_Valid), 32'h0);
    check_eq("arb_busy_ack", 32'(Arb_Busy), 32'h1);
    check_eq("terr_idle",  32'(Timeout_Err), 32'h0);
    if (drop) Req[w] = 1'b0;

    tick();
    check_eq("valid_pulse", 32'(Tx_Data_Valid), 32'h1);
    check_eq("ack_single",  32'(Req_Ack), 32'h0);
    check_eq("tx_data_v",   32'(Tx_Data), 32'(d));

    if (busy_len > 0) begin
      tick();
      check_eq("valid_single", 32'(Tx_Data_Valid), 32'h0);
      tick();
      Tx_Busy = 1'b1;
      repeat (busy_len) begin
        tick();
        check_eq("arb_busy_frame", 32'(Arb_Busy), 32'h1);
      end
      Tx_Busy = 1'b0;
      tick();
      check_eq("arb_busy_end", 32'(Arb_Busy), 32'h0);
      check_eq("terr_none",    32'(Timeout_Err), 32'h0);
      check_eq("tx_data_hold", 32'(Tx_Data), 32'(d));
    end else begin
      for (int i = 1; i < BT; i++) begin
        tick();
        check_eq("terr_early",   32'(Timeout_Err), 32'h0);
        check_eq("arb_busy_wait", 32'(Arb_Busy), 32'h1);
      end
      tick();
      check_eq("terr_pulse",   32'(Timeout_Err), 32'h1);
      check_eq("arb_busy_to",  32'(Arb_Busy), 32'h0);
      check_eq("tx_data_to",   32'(Tx_Data), 32'(d));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Single request, long frame.
    do_frame(4'b0100, 32'h00A5_0000, 11, 1'b1);
    Req = '0;
    tick();

    // All requesting, held high across frames.
    for (int f = 0; f < 5; f++) do_frame(4'b1111, 32'h1312_1110, 2, 1'b0);

    // Wrap-around.
    do_frame(4'b1000, 32'h4400_0000, 1, 1'b1);
    do_frame(4'b1001, 32'h5500_0066, 1, 1'b0);
    do_frame(4'b1001, 32'h5500_0066, 1, 1'b0);

    // Transmitter never answers, then a normal grant.
    do_frame(4'b0011, 32'h0000_7788, 0, 1'b1);
    do_frame(4'b0110, 32'h0099_AA00, 3, 1'b1);

    // Busy held in IDLE blocks grants.
    Tx_Busy = 1'b1;
    Req     = 4'b0101;
    repeat (3) begin
      tick();
      check_eq("no_grant_busy", 32'(Req_Ack), 32'h0);
      check_eq("idle_busy_arb", 32'(Arb_Busy), 32'h0);
    end
    Tx_Busy = 1'b0;
    do_frame(4'b0101, 32'h00C3_00D4, 2, 1'b1);

    // Reset while in WAIT_DONE.
    Req      = 4'b0100;
    Req_Data = 32'h00E7_0000;
    w        = model_pick(Req);
    ptr_m    = (w + 1) % N;
    tick();
    check_eq("rst_pre_ack", 32'(Req_Ack), 32'(1 << w));
    Req = '0;
    tick();
    tick();
    tick();
    Tx_Busy = 1'b1;
    tick();
    tick();
    check_eq("rst_pre_busy", 32'(Arb_Busy), 32'h1);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("async_rst");
    Tx_Busy = 1'b0;
    ptr_m   = 0;
    @(negedge CLK);
    RST = 1'b1;
    tick();
    do_frame(4'b1010, 32'h3C00_5A00, 3, 1'b1);

    // Randomized frames.
    for (int f = 0; f < 150; f++) begin
      logic [N-1:0] r;
      int bl;
      r = N'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) begin
        Tx_Busy = 1'b1;
        Req     = r;
        repeat ($urandom_range(1, 3)) begin
          tick();
          check_eq("rnd_no_grant", 32'(Req_Ack), 32'h0);
        end
        Tx_Busy = 1'b0;
      end
      bl = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      do_frame(r, $urandom, bl, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
- Grants one requester per byte and latches its data.
- Issues a single-cycle Data_Valid pulse to the UART TX controller, then tracks the TX Busy output until the frame completes.
- Sits between the requesting blocks (register file, status reporter, loopback, etc.) and the UART TX top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width forwarded to the transmitter
ID_WIDTH, 2, width of Grant_Id; must satisfy 2**ID_WIDTH >= NUM_REQ
BUSY_TIMEOUT, 8, cycles allowed in WAIT_BUSY for Tx_Busy to rise before abort (>= 3)

Ports:
CLK  input  1  clock
RST  input  1  asynchronous reset, active-low
Req  input  NUM_REQ  per-requester request level; held until matching Req_Ack
Req_Data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
Req_Ack  output  NUM_REQ  one-hot single-cycle pulse: byte accepted (latched)
Tx_Busy  input  1  Busy from the UART TX controller
Tx_Data  output  DATA_WIDTH  byte to the transmitter; stable from grant until return to IDLE
Tx_Data_Valid  output  1  single-cycle start pulse to the transmitter
Grant_Id  output  ID_WIDTH  index of the current/last granted requester
Arb_Busy  output  1  high in every state except IDLE
Timeout_Err  output  1  single-cycle pulse when BUSY_TIMEOUT expires

Behaviour:
- Reset (RST=0, async) puts all outputs to 0: Tx_Data, Tx_Data_Valid, Req_Ack, Grant_Id, Arb_Busy, Timeout_Err. The round-robin pointer resets to 0, the timeout counter resets to 0, and state resets to IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any Req bit is set and Tx_Busy=0: select the winner, latch its data into Tx_Data, set Grant_Id, pulse Req_Ack[winner] for 1 cycle, and go to ISSUE.
  - If Tx_Busy=1 in IDLE, there is no grant; stay in IDLE.
- Winner selection: the first set Req bit searching upward from the pointer, wrapping from NUM_REQ-1 to 0. After a grant, the pointer becomes winner+1 modulo NUM_REQ.
- ISSUE: Tx_Data_Valid=1 for exactly this cycle; go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - If Tx_Busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with Tx_Busy still 0, pulse Timeout_Err and go to IDLE.
  - The byte is dropped on timeout and is not re-sent; the pointer is already advanced.
  - The nominal TX controller raises Busy on the 2nd cycle after the Data_Valid cycle.
- WAIT_DONE: when Tx_Busy=0, go to IDLE. The next grant can occur in that IDLE cycle.
- Grant-to-Data_Valid latency is 1 cycle (Req_Ack cycle, then Tx_Data_Valid cycle).
- Req_Ack and Tx_Data_Valid are never high in the same cycle.
- Requests arriving while Arb_Busy=1 wait; nothing is queued beyond the Req level.
- A Req drop after Ack has no effect on the frame in flight.
- If Req[i] is dropped before Ack (a protocol violation), i is not granted and no ack is issued.
- Tx_Data stays constant from the grant until the next grant; it is not cleared on return to IDLE.
- Fairness: with all Req held high, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 frames.
- Reset asserted mid-frame aborts immediately with no Ack replay. The transmitter is reset by the same RST.

Optional Feature:
UART_ARB_FIXED_PRIO_EN
- Defined: winner is the lowest-index set Req bit; the round-robin pointer is not implemented; all other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, Req=4'b0100, Req_Data[2]=8'hA5, TX model raises Busy 2 cycles after Valid and holds it 11 cycles -> Req_Ack=4'b0100 for 1 cycle, Tx_Data=8'hA5 and Tx_Data_Valid pulse on the next cycle, Grant_Id=2, Arb_Busy high until the cycle after Busy falls.
- Req=4'b1111 held for 5 frames with data 8'h10..8'h13 -> grant order 0,1,2,3,0; Tx_Data sequence 10,11,12,13,10.
- After a grant to requester 3, Req=4'b1001 -> next grant is 0 (wrap); then with Req=4'b1001 again, next grant is 3.
- TX model never raises Busy -> Timeout_Err pulses exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; return to IDLE; next pending Req granted normally.
- Assert RST in WAIT_DONE -> all outputs 0 asynchronously; after release, Req=4'b0010 is granted to 1 (pointer back at 0).
- With UART_ARB_FIXED_PRIO_EN, Req=4'b1111 held -> every grant goes to 0; requester 3 never acked.
